// File: rtl/keypad_pkg.sv
// Shared keypad definitions: key codes, active-low line codes, emulator states
// and the key-to-matrix mapping used by both the emulator and the decoder.
package keypad_pkg;

    typedef logic [3:0] key_code_t;

    localparam key_code_t KEY_0    = 4'h0;
    localparam key_code_t KEY_1    = 4'h1;
    localparam key_code_t KEY_2    = 4'h2;
    localparam key_code_t KEY_3    = 4'h3;
    localparam key_code_t KEY_4    = 4'h4;
    localparam key_code_t KEY_5    = 4'h5;
    localparam key_code_t KEY_6    = 4'h6;
    localparam key_code_t KEY_7    = 4'h7;
    localparam key_code_t KEY_8    = 4'h8;
    localparam key_code_t KEY_9    = 4'h9;
    localparam key_code_t KEY_A    = 4'hA;
    localparam key_code_t KEY_B    = 4'hB;
    localparam key_code_t KEY_C    = 4'hC;
    localparam key_code_t KEY_D    = 4'hD;
    localparam key_code_t KEY_HASH = 4'hE;
    localparam key_code_t KEY_STAR = 4'hF;

    // Index 0 is the MSB line, so line n is driven low on bit (3-n).
    typedef enum logic [3:0] {
        LINE_0 = 4'b0111,
        LINE_1 = 4'b1011,
        LINE_2 = 4'b1101,
        LINE_3 = 4'b1110
    } line_code_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BOUNCE_PRESS,
        ST_HOLD,
        ST_BOUNCE_RELEASE,
        ST_GAP
    } emu_state_t;

    // Keypad layout: r0 = 1 2 3 A, r1 = 4 5 6 B, r2 = 7 8 9 C, r3 = * 0 # D.
    function automatic logic [1:0] key_to_row(key_code_t code);
        case (code)
            KEY_1, KEY_2, KEY_3, KEY_A: key_to_row = 2'd0;
            KEY_4, KEY_5, KEY_6, KEY_B: key_to_row = 2'd1;
            KEY_7, KEY_8, KEY_9, KEY_C: key_to_row = 2'd2;
            default:                    key_to_row = 2'd3;
        endcase
    endfunction

    function automatic logic [1:0] key_to_col(key_code_t code);
        case (code)
            KEY_1, KEY_4, KEY_7, KEY_STAR: key_to_col = 2'd0;
            KEY_2, KEY_5, KEY_8, KEY_0:    key_to_col = 2'd1;
            KEY_3, KEY_6, KEY_9, KEY_HASH: key_to_col = 2'd2;
            default:                       key_to_col = 2'd3;
        endcase
    endfunction

    function automatic line_code_t line_code(logic [1:0] idx);
        case (idx)
            2'd0:    line_code = LINE_0;
            2'd1:    line_code = LINE_1;
            2'd2:    line_code = LINE_2;
            default: line_code = LINE_3;
        endcase
    endfunction

endpackage

// File: rtl/matrix_key_emulator.sv
// Passive 4x4 keypad model: takes a key code over valid/ready and answers the
// row scan on the column lines, with press bounce, hold, release bounce and gap.
module matrix_key_emulator
    import keypad_pkg::*;
#(
    parameter int BOUNCE_CYCLES = 20,
    parameter int BOUNCE_TOGGLE = 3,
    parameter int HOLD_CYCLES   = 200,
    parameter int GAP_CYCLES    = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key_code,
    input  logic       key_req,
    output logic       key_ready,
    input  logic [3:0] lin_matrix,
    output logic [3:0] col_matrix,
    output logic       key_busy,
    output logic       key_done
);

    localparam int MAX_BH = (BOUNCE_CYCLES > HOLD_CYCLES) ? BOUNCE_CYCLES : HOLD_CYCLES;
    localparam int MAX_P  = (MAX_BH > GAP_CYCLES) ? MAX_BH : GAP_CYCLES;
    localparam int CNT_W  = $clog2(MAX_P + 1);
    localparam int TOG_W  = $clog2(BOUNCE_TOGGLE + 1);

    // Counters hold "cycles remaining minus one" so zero marks the last cycle.
    localparam logic [CNT_W-1:0] B_LOAD = CNT_W'((BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] H_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] G_LOAD = CNT_W'(GAP_CYCLES - 1);
    localparam logic [TOG_W-1:0] T_LOAD = TOG_W'(BOUNCE_TOGGLE - 1);

    emu_state_t       state_q;
    logic             contact_q;
    logic             done_q;
    logic [CNT_W-1:0] cnt_q;
    logic [TOG_W-1:0] tog_q;
    logic [1:0]       row_q;
    logic [1:0]       col_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            contact_q <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
            tog_q     <= '0;
            row_q     <= '0;
            col_q     <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (key_req) begin
                        row_q     <= key_to_row(key_code);
                        col_q     <= key_to_col(key_code);
                        contact_q <= 1'b1;
                        if (BOUNCE_CYCLES == 0) begin
                            state_q <= ST_HOLD;
                            cnt_q   <= H_LOAD;
                        end else begin
                            state_q <= ST_BOUNCE_PRESS;
                            cnt_q   <= B_LOAD;
                            tog_q   <= T_LOAD;
                        end
                    end
                end
                ST_BOUNCE_PRESS, ST_BOUNCE_RELEASE: begin
                    if (cnt_q == '0) begin
                        // Leaving a bounce phase forces the contact to its solid level.
                        if (state_q == ST_BOUNCE_PRESS) begin
                            state_q   <= ST_HOLD;
                            cnt_q     <= H_LOAD;
                            contact_q <= 1'b1;
                        end else begin
                            state_q   <= ST_GAP;
                            cnt_q     <= G_LOAD;
                            contact_q <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (tog_q == '0) begin
                            contact_q <= ~contact_q;
                            tog_q     <= T_LOAD;
                        end else begin
                            tog_q <= tog_q - TOG_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == '0) begin
                        contact_q <= 1'b0;
                        if (BOUNCE_CYCLES == 0) begin
                            state_q <= ST_GAP;
                            cnt_q   <= G_LOAD;
                        end else begin
                            state_q <= ST_BOUNCE_RELEASE;
                            cnt_q   <= B_LOAD;
                            tog_q   <= T_LOAD;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    contact_q <= 1'b0;
                end
            endcase
        end
    end

    // Only the latched row matters; ~row_q selects lin_matrix bit (3-row).
    assign col_matrix = (contact_q && !lin_matrix[~row_q]) ? line_code(col_q) : 4'b1111;
    assign key_ready  = (state_q == ST_IDLE);
    assign key_busy   = (state_q != ST_IDLE);
    assign key_done   = done_q;

endmodule

// File: tb/tb_matrix_key_emulator.sv
// Randomized self-checking bench for matrix_key_emulator: one instance without
// bounce and one with bounce, both checked every cycle against a timeline model.
module tb_matrix_key_emulator;

    localparam logic [63:0] KEYMAP = 64'h123A_456B_789C_F0ED;

    logic       clk;
    logic       reset;
    logic [3:0] keyCode [2];
    logic       keyReq  [2];
    logic [3:0] lin     [2];
    logic [3:0] col     [2];
    logic       ready   [2];
    logic       busy    [2];
    logic       done    [2];

    int nChecks;
    int nFails;

    matrix_key_emulator #(
        .BOUNCE_CYCLES(0), .BOUNCE_TOGGLE(1), .HOLD_CYCLES(12), .GAP_CYCLES(7)
    ) dutFast (
        .clk(clk), .reset(reset), .key_code(keyCode[0]), .key_req(keyReq[0]),
        .key_ready(ready[0]), .lin_matrix(lin[0]), .col_matrix(col[0]),
        .key_busy(busy[0]), .key_done(done[0])
    );

    matrix_key_emulator #(
        .BOUNCE_CYCLES(20), .BOUNCE_TOGGLE(3), .HOLD_CYCLES(15), .GAP_CYCLES(10)
    ) dutBounce (
        .clk(clk), .reset(reset), .key_code(keyCode[1]), .key_req(keyReq[1]),
        .key_ready(ready[1]), .lin_matrix(lin[1]), .col_matrix(col[1]),
        .key_busy(busy[1]), .key_done(done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pBounce(int inst); return (inst == 0) ? 0  : 20; endfunction
    function automatic int pToggle(int inst); return (inst == 0) ? 1  : 3;  endfunction
    function automatic int pHold(int inst);   return (inst == 0) ? 12 : 15; endfunction
    function automatic int pGap(int inst);    return (inst == 0) ? 7  : 10; endfunction

    // Locate a key on the physical layout by searching the 4x4 map.
    task automatic keyPos(input logic [3:0] code, output int r, output int c);
        logic [3:0] entry;
        r = 0;
        c = 0;
        for (int i = 0; i < 16; i++) begin
            entry = KEYMAP[63 - 4*i -: 4];
            if (entry == code) begin
                r = i / 4;
                c = i % 4;
            end
        end
    endtask

    // Contact level k cycles after the accepting edge, from the phase timeline.
    function automatic bit modelClosed(int inst, int k);
        int b = pBounce(inst);
        int t = pToggle(inst);
        int h = pHold(inst);
        if (k < b)              return ((k / t) % 2) == 0;
        else if (k < b + h)     return 1'b1;
        else if (k < 2*b + h)   return (((k - b - h) / t) % 2) == 1;
        else                    return 1'b0;
    endfunction

    // linMode: 0 correct row only, 1 sweep rows, 2 random.
    // reqMode: 0 single pulse, 1 extra pulse at pokeAt, 2 held and chained, 3 held then dropped.
    task automatic runKeySequence(input int inst, input logic [3:0] code, input int linMode,
                                  input int reqMode, input int pokeAt,
                                  input logic [3:0] nextCode, input bit chained);
        int r, c, len;
        bit closed;
        logic [3:0] expCol;
        logic [2:0] expStat;
        keyPos(code, r, c);
        len = 2*pBounce(inst) + pHold(inst) + pGap(inst);
        if (!chained) begin
            @(negedge clk);
            keyCode[inst] = code;
            keyReq[inst]  = 1'b1;
        end
        for (int k = 0; k <= len; k++) begin
            @(negedge clk);
            keyCode[inst] = 4'($urandom);
            if (reqMode <= 1) keyReq[inst] = (reqMode == 1) && (k == pokeAt);
            else              keyReq[inst] = (k < len) || (reqMode == 2);
            if (reqMode == 1 && k == pokeAt) keyCode[inst] = code ^ 4'h9;
            if (reqMode == 2 && k == len)    keyCode[inst] = nextCode;
            case (linMode)
                0:       lin[inst] = ~(4'b1000 >> r);
                1:       lin[inst] = ~(4'b1000 >> (k % 4));
                default: lin[inst] = 4'($urandom);
            endcase
            #1;
            closed  = modelClosed(inst, k);
            expCol  = (k < len && closed && lin[inst][3-r] == 1'b0) ? ~(4'b1000 >> c) : 4'b1111;
            expStat = {k < len, k >= len, k == len};
            nChecks++;
            if (col[inst] !== expCol) begin
                nFails++;
                $display("[TB] FAIL colMatrix inst=%0d key=%h k=%0d lin=%b got=%b exp=%b",
                         inst, code, k, lin[inst], col[inst], expCol);
            end
            nChecks++;
            if ({busy[inst], ready[inst], done[inst]} !== expStat) begin
                nFails++;
                $display("[TB] FAIL status{busy,ready,done} inst=%0d key=%h k=%0d got=%b exp=%b",
                         inst, code, k, {busy[inst], ready[inst], done[inst]}, expStat);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        lin[0] = 4'b0000;
        lin[1] = 4'b0000;
        #1;
        for (int i = 0; i < 2; i++) begin
            nChecks++;
            if ({col[i], busy[i], ready[i], done[i]} !== 7'b1111_010) begin
                nFails++;
                $display("[TB] FAIL resetState inst=%0d got=%b exp=%b", i,
                         {col[i], busy[i], ready[i], done[i]}, 7'b1111_010);
            end
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_no_bounce();
        runKeySequence(0, 4'h5, 0, 0, -1, 4'h0, 1'b0);
    endtask

    task automatic test_row_sweep();
        runKeySequence(0, 4'hF, 1, 0, -1, 4'h0, 1'b0);
    endtask

    task automatic test_bounce();
        runKeySequence(1, 4'h9, 0, 0, -1, 4'h0, 1'b0);
        runKeySequence(1, 4'hD, 0, 0, -1, 4'h0, 1'b0);
    endtask

    task automatic test_all_keys();
        for (int i = 0; i < 16; i++) runKeySequence(0, 4'(i), 2, 0, -1, 4'h0, 1'b0);
        for (int i = 0; i < 3; i++) runKeySequence(1, 4'($urandom), 2, 0, -1, 4'h0, 1'b0);
    endtask

    task automatic test_busy_ignore();
        runKeySequence(1, 4'hA, 0, 1, 25, 4'h0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            nChecks++;
            if ({busy[1], ready[1], done[1], col[1]} !== 7'b010_1111) begin
                nFails++;
                $display("[TB] FAIL idleAfterIgnore k=%0d got=%b exp=%b", k,
                         {busy[1], ready[1], done[1], col[1]}, 7'b010_1111);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        @(negedge clk);
        keyCode[1] = 4'h7;
        keyReq[1]  = 1'b1;
        lin[1]     = 4'b1101;
        for (int k = 0; k < 26; k++) begin
            @(negedge clk);
            keyReq[1] = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        nChecks++;
        if ({col[1], busy[1], ready[1], done[1]} !== 7'b1111_010) begin
            nFails++;
            $display("[TB] FAIL resetMidHold got=%b exp=%b",
                     {col[1], busy[1], ready[1], done[1]}, 7'b1111_010);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #1;
            nChecks++;
            if ({col[1], done[1]} !== 5'b1111_0) begin
                nFails++;
                $display("[TB] FAIL quietAfterReset k=%0d got=%b exp=%b", k,
                         {col[1], done[1]}, 5'b1111_0);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] codes [5];
        for (int i = 0; i < 5; i++) codes[i] = 4'($urandom);
        for (int i = 0; i < 4; i++)
            runKeySequence(0, codes[i], 2, 2, -1, codes[i+1], i != 0);
        runKeySequence(0, codes[4], 2, 3, -1, 4'h0, 1'b1);
    endtask

    initial begin
        nChecks = 0;
        nFails  = 0;
        reset   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            keyCode[i] = 4'h0;
            keyReq[i]  = 1'b0;
            lin[i]     = 4'b1111;
        end
        test_reset();
        test_no_bounce();
        test_row_sweep();
        test_bounce();
        test_all_keys();
        test_busy_ignore();
        test_reset_mid_hold();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
